// File: rtl/issue_rename_if.sv
// issue_rename_if: decode, reservation-station, CDB and commit signals of the issue/rename stage
interface issue_rename_if #(
  parameter int NREG = 16,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W = 16,
  parameter int FUNC_W = 4
);
  localparam int RW = $clog2(NREG);
  localparam int TW = $clog2(ROB_DEPTH);
  logic in_valid, in_ready;
  logic [RW-1:0] in_rs1, in_rs2, in_rd;
  logic [FUNC_W-1:0] in_func;
  logic rs_valid;
  logic [1:0] rs_class;
  logic [FUNC_W-1:0] rs_func;
  logic [TW-1:0] rs_rob_tag;
  logic rs_rdy1, rs_rdy2;
  logic [DATA_W-1:0] rs_val1, rs_val2;
  logic [TW-1:0] rs_tag1, rs_tag2;
  logic [2:0] rs_free;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic commit_valid;
  logic [TW-1:0] commit_tag;
  logic [RW-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;
  modport slave (
    input in_valid, in_rs1, in_rs2, in_rd, in_func, rs_free, cdb_valid, cdb_tag, cdb_data,
    output in_ready, rs_valid, rs_class, rs_func, rs_rob_tag, rs_rdy1, rs_rdy2, rs_val1, rs_val2,
    rs_tag1, rs_tag2, commit_valid, commit_tag, commit_rd, commit_data
  );
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_func, rs_free, cdb_valid, cdb_tag, cdb_data,
    input in_ready, rs_valid, rs_class, rs_func, rs_rob_tag, rs_rdy1, rs_rdy2, rs_val1, rs_val2,
    rs_tag1, rs_tag2, commit_valid, commit_tag, commit_rd, commit_data
  );
endinterface

// File: rtl/issue_rename_unit.sv
// issue_rename_unit: Tomasulo issue stage with RAT renaming, ROB allocation and in-order commit
// Define ISSUE_CDB_BYPASS_EN to forward a same-cycle CDB result into issuing operands.
module issue_rename_unit #(
  parameter int NREG = 16,
  parameter int ROB_DEPTH = 8,
  parameter int RS_PER_CLASS = 3,
  parameter int DATA_W = 16,
  parameter int FUNC_W = 4
) (
  input logic clk1,
  input logic rst,
  issue_rename_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int OW = $clog2(RS_PER_CLASS + 1);
  logic [DATA_W-1:0] regfile [NREG];
  logic rat_busy [NREG];
  logic [TW-1:0] rat_tag [NREG];
  logic [RW-1:0] rob_rd [ROB_DEPTH];
  logic rob_dest [ROB_DEPTH];
  logic rob_done [ROB_DEPTH];
  logic [DATA_W-1:0] rob_val [ROB_DEPTH];
  logic [TW:0] head, tail;
  logic [OW-1:0] occ [3];
  logic [1:0] fcls, cls;
  logic [RW-1:0] src [2];
  logic rdy [2];
  logic hit [2];
  logic [DATA_W-1:0] val [2];
  logic [TW-1:0] tag [2];
  logic [TW-1:0] hi, ti;
  logic full, stall, fire, do_commit;
  assign hi = head[TW-1:0];
  assign ti = tail[TW-1:0];
  assign fcls = bus.in_func[FUNC_W-1 -: 2];
  assign cls = fcls == 2'b11 ? 2'b00 : fcls;
  assign src[0] = bus.in_rs1;
  assign src[1] = bus.in_rs2;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tag[i] = rat_tag[src[i]];
      hit[i] = bus.cdb_valid && rat_busy[src[i]] && bus.cdb_tag == tag[i];
`ifdef ISSUE_CDB_BYPASS_EN
      rdy[i] = !rat_busy[src[i]] || hit[i] || rob_done[tag[i]];
      val[i] = !rat_busy[src[i]] ? regfile[src[i]] : hit[i] ? bus.cdb_data : rob_val[tag[i]];
`else
      rdy[i] = !rat_busy[src[i]] || rob_done[tag[i]];
      val[i] = !rat_busy[src[i]] ? regfile[src[i]] : rob_val[tag[i]];
`endif
    end
  end
`ifdef ISSUE_CDB_BYPASS_EN
  assign stall = 1'b0;
`else
  // without bypass, hold the instruction one cycle so it picks the result up from the ROB
  assign stall = hit[0] || hit[1];
`endif
  assign full = hi == ti && head[TW] != tail[TW];
  assign bus.in_ready = !rst && !full && occ[cls] < OW'(RS_PER_CLASS) && !stall;
  assign fire = bus.in_valid && bus.in_ready;
  assign do_commit = head != tail && rob_done[hi];
  assign bus.rs_valid = fire;
  assign bus.rs_class = cls;
  assign bus.rs_func = bus.in_func;
  assign bus.rs_rob_tag = ti;
  assign bus.rs_rdy1 = rdy[0];
  assign bus.rs_rdy2 = rdy[1];
  assign bus.rs_val1 = val[0];
  assign bus.rs_val2 = val[1];
  assign bus.rs_tag1 = tag[0];
  assign bus.rs_tag2 = tag[1];
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regfile[i] <= '0;
        rat_busy[i] <= 1'b0;
        rat_tag[i] <= '0;
      end
      for (int i = 0; i < ROB_DEPTH; i++) rob_done[i] <= 1'b0;
      for (int i = 0; i < 3; i++) occ[i] <= '0;
      head <= '0;
      tail <= '0;
      bus.commit_valid <= 1'b0;
      bus.commit_tag <= '0;
      bus.commit_rd <= '0;
      bus.commit_data <= '0;
    end else begin
      for (int c = 0; c < 3; c++)
        occ[c] <= occ[c] + OW'(fire && cls == 2'(c)) - OW'(bus.rs_free[c] && occ[c] != '0);
      if (bus.cdb_valid) begin
        rob_done[bus.cdb_tag] <= 1'b1;
        rob_val[bus.cdb_tag] <= bus.cdb_data;
      end
      bus.commit_valid <= do_commit;
      if (do_commit) begin
        if (rob_dest[hi]) regfile[rob_rd[hi]] <= rob_val[hi];
        if (rat_tag[rob_rd[hi]] == hi) rat_busy[rob_rd[hi]] <= 1'b0;
        rob_done[hi] <= 1'b0;
        head <= head + (TW+1)'(1);
        bus.commit_tag <= hi;
        bus.commit_rd <= rob_rd[hi];
        bus.commit_data <= rob_val[hi];
      end
      // placed after commit so a same-cycle rename of the retiring rd keeps it busy
      if (fire) begin
        rob_rd[ti] <= bus.in_rd;
        rob_dest[ti] <= cls != 2'd2;
        rob_done[ti] <= 1'b0;
        tail <= tail + (TW+1)'(1);
        if (cls != 2'd2) begin
          rat_busy[bus.in_rd] <= 1'b1;
          rat_tag[bus.in_rd] <= ti;
        end
      end
    end
  end
endmodule
